// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands and START; the slave reports BUSY/DONE and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, x, y, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, x, y, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = X - Y - BORROW_IN, one bit per clock, LSB first.
// One full-subtractor cell and a borrow flop; operands and result live in shift registers.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] d_q;
  logic             b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic [WIDTH-1:0] d_sr_d;
  logic             b_d;
  logic             dbit;
  logic             last_bit;

  // Returns {borrow_out, difference} of a single full-subtractor cell.
  function automatic logic [1:0] fsub(input logic xb, input logic yb, input logic bb);
    logic d;
    logic bo;
    d  = xb ^ yb ^ bb;
    bo = (~xb & yb) | (~(xb ^ yb) & bb);
    return {bo, d};
  endfunction

  always_comb begin
    {b_d, dbit} = fsub(x_q[0], y_q[0], b_q);
    d_sr_d      = (d_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // FIN accepts a new START exactly like IDLE so operations can run back to back.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, FIN: begin
          if (bus.start) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            b_q     <= bus.borrow_in;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          d_q   <= d_sr_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            diff_q  <= d_sr_d;
            bout_q  <= b_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule
